// File: rtl/lamp_monitor.sv
// Lamp-side conflict monitor: decodes the five crossing lamp drives into phases and
// latches the first illegal combination, order violation or dwell violation it sees.
module lamp_monitor #(
   parameter int MIN_YELLOW = 2,
   parameter int MIN_RED    = 2,
   parameter int MIN_WALK   = 6,
   parameter int MIN_CLEAR  = 6,
   parameter int MIN_GREEN  = 12,
   parameter int MAX_DWELL  = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       TR,
   input  logic       TY,
   input  logic       TG,
   input  logic       PR,
   input  logic       PG,
   input  logic       clr,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [2:0] phase,
   output logic [7:0] walk_count
);

   localparam logic [4:0] L_MAX_LIMIT = 5'(MAX_DWELL + 1);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_GREEN  = 3'd1,
      S_YELLOW = 3'd2,
      S_RED1   = 3'd3,
      S_WALK   = 3'd4,
      S_CLEAR  = 3'd5,
      S_RED2   = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      L_G, L_Y, L_R, L_W, L_C, L_ILLEGAL
   } lamp_t;

   logic [4:0] r_lamp;
   logic       r_sampleValid;
   state_t     r_state, w_stateNext, w_target;
   logic [4:0] r_dwell, w_dwellNext, w_dwellStay, w_minDwell;
   logic       r_armed, w_armedNext;
   logic [2:0] r_faultCode, w_faultCodeNext;
   logic [7:0] r_walkCount;
   logic       w_walkInc;
   logic       w_badMove;
   lamp_t      w_code;

   // lamp_q only holds a real sample after the first edge out of reset; the tracker waits for it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lamp        <= 5'd0;
         r_sampleValid <= 1'b0;
      end else begin
         r_lamp        <= {TR, TY, TG, PR, PG};
         r_sampleValid <= 1'b1;
      end
   end

   always_comb begin
      case (r_lamp)
         5'b00110: w_code = L_G;
         5'b01010: w_code = L_Y;
         5'b10010: w_code = L_R;
         5'b10001: w_code = L_W;
         5'b10000: w_code = L_C;
         default:  w_code = L_ILLEGAL;
      endcase
   end

   always_comb begin
      w_target  = r_state;
      w_badMove = 1'b0;
      case (r_state)
         S_INIT:   if (w_code == L_G) w_target = S_GREEN;
         S_GREEN:  if (w_code == L_Y) w_target = S_YELLOW; else if (w_code != L_G) w_badMove = 1'b1;
         S_YELLOW: if (w_code == L_R) w_target = S_RED1;   else if (w_code != L_Y) w_badMove = 1'b1;
         S_RED1:   if (w_code == L_W) w_target = S_WALK;   else if (w_code != L_R) w_badMove = 1'b1;
         S_WALK:   if (w_code == L_C) w_target = S_CLEAR;  else if (w_code != L_W) w_badMove = 1'b1;
         S_CLEAR:  if (w_code == L_R) w_target = S_RED2;   else if (w_code != L_C) w_badMove = 1'b1;
         S_RED2: begin
            if (w_code == L_G)      w_target  = S_GREEN;
            else if (w_code == L_W) w_target  = S_WALK;
            else if (w_code != L_R) w_badMove = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (r_state)
         S_GREEN:        w_minDwell = r_armed ? 5'(MIN_GREEN) : 5'd0;
         S_YELLOW:       w_minDwell = 5'(MIN_YELLOW);
         S_RED1, S_RED2: w_minDwell = 5'(MIN_RED);
         S_WALK:         w_minDwell = 5'(MIN_WALK);
         S_CLEAR:        w_minDwell = 5'(MIN_CLEAR);
         default:        w_minDwell = 5'd0;
      endcase
      w_dwellStay = (r_dwell == 5'd31) ? r_dwell : r_dwell + 5'd1;
   end

   // Fault checks in priority order; the first hit parks the tracker in FAULT
   always_comb begin
      w_stateNext     = r_state;
      w_dwellNext     = r_dwell;
      w_armedNext     = r_armed;
      w_faultCodeNext = r_faultCode;
      w_walkInc       = 1'b0;
      if (!r_sampleValid) begin
         w_stateNext = r_state;
      end else if (r_state == S_FAULT) begin
         if (clr) begin
            w_stateNext     = S_INIT;
            w_dwellNext     = 5'd0;
            w_armedNext     = 1'b0;
            w_faultCodeNext = 3'd0;
         end
      end else if (w_code == L_ILLEGAL) begin
         w_stateNext     = S_FAULT;
         w_faultCodeNext = 3'd1;
      end else if (w_badMove) begin
         w_stateNext     = S_FAULT;
         w_faultCodeNext = 3'd2;
      end else if (w_target != r_state && r_dwell < w_minDwell) begin
         w_stateNext     = S_FAULT;
         w_faultCodeNext = 3'd3;
      end else if (w_target == r_state && r_state != S_INIT && r_state != S_GREEN
                   && w_dwellStay >= L_MAX_LIMIT) begin
         w_stateNext     = S_FAULT;
         w_faultCodeNext = 3'd4;
      end else begin
         w_stateNext = w_target;
         if (w_target != r_state) begin
            w_dwellNext = 5'd1;
            if (w_target == S_GREEN) w_armedNext = (r_state == S_RED2);
            w_walkInc = (r_state == S_CLEAR);
         end else if (r_state != S_INIT) begin
            w_dwellNext = w_dwellStay;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_INIT;
         r_dwell     <= 5'd0;
         r_armed     <= 1'b0;
         r_faultCode <= 3'd0;
         r_walkCount <= 8'd0;
      end else begin
         r_state     <= w_stateNext;
         r_dwell     <= w_dwellNext;
         r_armed     <= w_armedNext;
         r_faultCode <= w_faultCodeNext;
         if (w_walkInc) r_walkCount <= r_walkCount + 8'd1;
      end
   end

   assign fault      = (r_state == S_FAULT);
   assign fault_code = r_faultCode;
   assign phase      = r_state;
   assign walk_count = r_walkCount;

endmodule

// File: tb/tb_lamp_monitor.sv
// Scoreboard bench for lamp_monitor: a table-driven phase model predicts every edge's
// outputs, and a separate monitor compares them against the DUT.
module tb_lamp_monitor;

   localparam logic [4:0] LG = 5'b00110;
   localparam logic [4:0] LY = 5'b01010;
   localparam logic [4:0] LR = 5'b10010;
   localparam logic [4:0] LW = 5'b10001;
   localparam logic [4:0] LC = 5'b10000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       TR = 1'b0, TY = 1'b0, TG = 1'b0, PR = 1'b0, PG = 1'b0;
   logic       clr = 1'b0;
   logic       fault;
   logic [2:0] fault_code;
   logic [2:0] phase;
   logic [7:0] walk_count;

   always #5 clk = ~clk;

   lamp_monitor dut (
      .clk        (clk),
      .reset      (reset),
      .TR         (TR),
      .TY         (TY),
      .TG         (TG),
      .PR         (PR),
      .PG         (PG),
      .clr        (clr),
      .fault      (fault),
      .fault_code (fault_code),
      .phase      (phase),
      .walk_count (walk_count)
   );

   typedef struct packed {
      logic       f;
      logic [2:0] code;
      logic [2:0] ph;
      logic [7:0] wc;
   } obs_t;

   obs_t expQ[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: phases 0..7, lamp classes 0=G 1=Y 2=R 3=W 4=C 5=illegal
   int   succ[7][6];
   logic [4:0] mLamp;
   bit   mValid, mArmed, mFault;
   int   mPhase, mDwell, mCode, mWalk, mWalkTotal;

   function automatic int classify(input logic [4:0] v);
      case (v)
         LG: return 0;
         LY: return 1;
         LR: return 2;
         LW: return 3;
         LC: return 4;
         default: return 5;
      endcase
   endfunction

   function automatic int minOf(input int p, input bit armed);
      case (p)
         1: return armed ? 12 : 0;
         2: return 2;
         3, 6: return 2;
         4, 5: return 6;
         default: return 0;
      endcase
   endfunction

   task automatic initTable();
      for (int p = 0; p < 7; p++)
         for (int c = 0; c < 6; c++) succ[p][c] = -1;
      succ[1][0] = 1; succ[1][1] = 2;
      succ[2][1] = 2; succ[2][2] = 3;
      succ[3][2] = 3; succ[3][3] = 4;
      succ[4][3] = 4; succ[4][4] = 5;
      succ[5][4] = 5; succ[5][2] = 6;
      succ[6][2] = 6; succ[6][0] = 1; succ[6][3] = 4;
   endtask

   task automatic modelReset();
      mLamp = 5'd0; mValid = 0; mArmed = 0; mFault = 0;
      mPhase = 0; mDwell = 0; mCode = 0; mWalk = 0;
   endtask

   task automatic modelStep(input logic [4:0] lamps, input bit clrIn);
      int c, nxt, nf;
      if (mValid) begin
         c = classify(mLamp);
         if (mFault) begin
            if (clrIn) begin
               mFault = 0; mCode = 0; mPhase = 0; mDwell = 0; mArmed = 0;
            end
         end else begin
            nf = 0;
            nxt = mPhase;
            if (c == 5) nf = 1;
            else if (mPhase == 0) nxt = (c == 0) ? 1 : 0;
            else if (succ[mPhase][c] < 0) nf = 2;
            else nxt = succ[mPhase][c];
            if (nf == 0 && nxt != mPhase && mDwell < minOf(mPhase, mArmed)) nf = 3;
            if (nf == 0 && nxt == mPhase && mPhase >= 2 && mDwell + 1 > 15) nf = 4;
            if (nf != 0) begin
               mFault = 1; mCode = nf; mPhase = 7;
            end else if (nxt != mPhase) begin
               if (nxt == 1) mArmed = (mPhase == 6);
               if (mPhase == 5) begin
                  mWalk = (mWalk + 1) % 256;
                  mWalkTotal++;
               end
               mPhase = nxt;
               mDwell = 1;
            end else if (mPhase != 0) begin
               mDwell++;
            end
         end
      end
      mLamp = lamps;
      mValid = 1;
   endtask

   task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s t=%0t: got fault=%0d code=%0d phase=%0d walk=%0d, expected fault=%0d code=%0d phase=%0d walk=%0d",
                  name, $time, act.f, act.code, act.ph, act.wc, exp.f, exp.code, exp.ph, exp.wc);
      end
   endtask

   // One edge of stimulus; rstN=0 holds the DUT in reset and checks outputs drop at once
   task automatic applyStimulus(input logic [4:0] lamps, input bit clrIn, input bit rstN);
      obs_t e;
      @(negedge clk);
      {TR, TY, TG, PR, PG} = lamps;
      clr = clrIn;
      reset = rstN;
      if (!rstN) begin
         #1;
         checkOutput("reset_async", {fault, fault_code, phase, walk_count}, '0);
         modelReset();
      end else begin
         modelStep(lamps, clrIn);
      end
      e.f = mFault;
      e.code = 3'(mCode);
      e.ph = 3'(mPhase);
      e.wc = 8'(mWalk);
      expQ.push_back(e);
   endtask

   task automatic hold(input logic [4:0] lamps, input int n, input bit rnd);
      logic [4:0] v;
      bit c;
      for (int i = 0; i < n; i++) begin
         v = lamps;
         c = 0;
         if (rnd && $urandom_range(0, 399) == 0) v = 5'($urandom_range(0, 31));
         if (rnd && $urandom_range(0, 49) == 0) c = 1;
         applyStimulus(v, c, 1'b1);
      end
   endtask

   function automatic int pick(input int lo, input int hi);
      int r;
      r = int'($urandom_range(0, 99));
      if (r == 0) return 1;
      if (r == 1) return 17;
      return int'($urandom_range(hi, lo));
   endfunction

   task automatic recover();
      repeat (3) applyStimulus(LG, mFault, 1'b1);
   endtask

   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("edge", {fault, fault_code, phase, walk_count}, e);
         end
      end
   end

   initial begin
      int iter;
      initTable();
      modelReset();
      mWalkTotal = 0;
      applyStimulus(LG, 1'b0, 1'b0);
      applyStimulus(LG, 1'b0, 1'b0);
      hold(LG, 20, 0);
      hold(LY, 2, 0); hold(LR, 2, 0); hold(LW, 6, 0);
      hold(LC, 6, 0); hold(LR, 2, 0); hold(LG, 12, 0);
      applyStimulus(5'b11110, 1'b0, 1'b1);
      hold(LG, 2, 0);
      applyStimulus(LG, 1'b1, 1'b1);
      hold(LG, 3, 0);
      hold(LW, 2, 0);
      recover();
      hold(LG, 3, 0); hold(LY, 1, 0); hold(LR, 2, 0);
      recover();
      hold(LG, 12, 0); hold(LY, 2, 0); hold(LR, 2, 0); hold(LW, 16, 0);
      applyStimulus(5'b11111, 1'b0, 1'b1);
      hold(LG, 2, 0);
      recover();

      iter = 0;
      while (mWalkTotal < 262 && iter < 1000) begin
         iter++;
         hold(LG, pick(12, 15), 1);
         if (!mFault) hold(LY, pick(2, 4), 1);
         if (!mFault) hold(LR, pick(2, 4), 1);
         do begin
            if (!mFault) hold(LW, pick(6, 10), 1);
            if (!mFault) hold(LC, pick(6, 10), 1);
            if (!mFault) hold(LR, pick(2, 4), 1);
         end while (!mFault && $urandom_range(0, 2) == 0);
         if (mFault) recover();
      end

      recover();
      hold(LG, 12, 0); hold(LY, 2, 0); hold(LR, 2, 0); hold(LW, 3, 0);
      applyStimulus(LW, 1'b0, 1'b0);
      hold(LG, 3, 0);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lamp_monitor.md
# lamp_monitor

Independent conflict monitor on the lamp side of the pedestrian crossing controller: it consumes the five lamp drives (TR, TY, TG, PR, PG) and decodes them back into crossing phases. It checks each sample for illegal lamp combinations, checks phase order, and checks phase dwell times against configured limits. On the first violation it latches a fault code; the board-level fail-safe uses that fault to force flashing red.

## Interface
- MIN_YELLOW, 2: minimum samples in YELLOW.
- MIN_RED, 2: minimum samples in each all-red phase.
- MIN_WALK, 6: minimum samples in WALK.
- MIN_CLEAR, 6: minimum samples in CLEAR.
- MIN_GREEN, 12: minimum samples in GREEN; applies only to a green entered from RED2.
- MAX_DWELL, 15: maximum samples in any non-green phase.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- TR, TY, TG, PR, PG  in  1 each  lamp drives from the crossing controller.
- clr  in  1  synchronous fault clear; takes effect only while a fault is latched.
- fault  out  1  sticky fault flag.
- fault_code  out  3  first fault seen: 0 none, 1 illegal combination, 2 illegal transition, 3 phase too short, 4 phase too long.
- phase  out  3  decoded tracker state: 0 INIT, 1 GREEN, 2 YELLOW, 3 RED1, 4 WALK, 5 CLEAR, 6 RED2, 7 FAULT.
- walk_count  out  8  completed pedestrian cycles, wraps modulo 256.

## Operation
- Lamp inputs are registered into lamp_q on every rising edge. All decoding uses lamp_q only.
- Decoded codes of lamp_q {TR,TY,TG,PR,PG}:
  - 00110 = G (green)
  - 01010 = Y (yellow)
  - 10010 = R (all red)
  - 10001 = W (walk)
  - 10000 = C (clear; the flashing PG samples low at the rising edge)
  - every other value = ILLEGAL
- Tracker FSM:
  - INIT: on G, go to GREEN. Any other legal code keeps INIT. ILLEGAL causes fault 1.
  - GREEN: stays on G; Y goes to YELLOW.
  - YELLOW: stays on Y; R goes to RED1.
  - RED1: stays on R; W goes to WALK.
  - WALK: stays on W; C goes to CLEAR.
  - CLEAR: stays on C; R goes to RED2. This transition increments walk_count.
  - RED2: stays on R; G goes to GREEN (min-green check armed); W goes to WALK (back-to-back request).
  - In GREEN through RED2, any other legal code causes fault 2.
- Dwell counter:
  - 5-bit, saturates at 31, reset to 1 on every phase change.
  - On leaving a phase, if dwell is below that phase's minimum: fault 3.
  - In any non-green phase, dwell reaching MAX_DWELL+1: fault 4.
  - GREEN has no maximum.
- Fault priority within one cycle: 1 > 2 > 3 > 4.
- Fault latch:
  - On the first fault, fault=1, fault_code is set, and phase=7.
  - Later faults are ignored.
  - walk_count freezes while fault is latched.
- clr=1 while fault is latched: at the next edge, fault=0, fault_code=0, phase=INIT, dwell=0, min-green check disarmed. walk_count is kept.
- clr while no fault is latched has no effect.

## Timing
- Reset (asynchronous, active-low): lamp_q=0, fault=0, fault_code=0, phase=0, walk_count=0, dwell=0. The release is honoured at the first edge after reset goes high.
- Latency: a lamp value present at edge k is in lamp_q after k. The resulting phase, fault and walk_count are visible after edge k+1. Fault latency is 2 edges from the offending input.
- The min-green check is armed only by the RED2→GREEN transition. The first green after reset or clr is unchecked.
- Dwell counts samples: a phase held across n edges of lamp_q has dwell n at the change.
- Reset mid-fault or mid-phase restarts from INIT. There is no memory of the prior state.
- clr and a new violation in the same cycle: the clear wins. The violation is re-evaluated from INIT.
- walk_count wraps from 255 to 0 without a fault.

## Test plan
- Reset low then high, drive G for 20 cycles → phase=1 two edges after the first G, fault=0, walk_count=0.
- Full legal cycle G12/Y2/R2/W6/C6/R2/G12 → phase steps 1,2,3,4,5,6,1; walk_count=1; fault=0.
- From GREEN, drive 11110 (TR and TG both high) → fault=1, fault_code=1, phase=7 two edges later. Assert clr → fault=0, phase=0.
- From GREEN, jump directly to W → fault_code=2. From YELLOW, hold Y 1 cycle then R → fault_code=3.
- Hold W for 16 samples → fault_code=4 at dwell 16. Drive an ILLEGAL combination afterwards → fault_code stays 4.
- 256 legal pedestrian cycles including back-to-back RED2→WALK → walk_count wraps to 0, fault=0. Pulse reset low mid-WALK → all outputs 0 immediately.
